// File: rtl/ahb_arbiter_rr.sv
// Multi-master AHB arbiter: round-robin or fixed-priority selection at burst
// boundaries, per-grant NONSEQ limit, lock-aware, registered grant/hmaster/hmastlock.
module ahb_arbiter_rr #(
  parameter int N_MASTERS      = 3,
  parameter int MW             = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1,
  parameter int MODE           = 0,
  parameter int MAX_HOLD       = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [N_MASTERS-1:0] hbusreq,
  input  logic [N_MASTERS-1:0] hlock,
  input  logic [1:0]           htrans,
  input  logic                 hready,
  output logic [N_MASTERS-1:0] hgrant,
  output logic [MW-1:0]        hmaster,
  output logic                 hmastlock
);

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);
  localparam logic [N_MASTERS-1:0] DEF_GRANT =
    {{(N_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;
  localparam logic [1:0] NONSEQ = 2'b10;

  // Handshake: a transfer phase completes on any edge with hready=1; with
  // hready=0 every piece of arbiter state is frozen.

  logic [MW-1:0]        owner_q;
  logic [HW-1:0]        hold_q;
  logic [MW-1:0]        next_owner;
  logic [MW-1:0]        pick;
  logic [MW-1:0]        cidx;
  logic [N_MASTERS-1:0] next_grant;
  logic [HW-1:0]        next_hold;
  logic                 ap;
  logic                 limit_hit;
  logic                 clear_hold;
  int                   c;

  always_comb begin
    c          = 0;
    cidx       = '0;
    pick       = DEF_IDX;
    next_owner = owner_q;
    clear_hold = 1'b0;
    next_grant = '0;
    next_hold  = hold_q;

    // IDLE (00) and NONSEQ (10) are the only boundaries; a held lock blocks them.
    ap        = hready && !htrans[0] && !(hlock[owner_q] && hbusreq[owner_q]);
    limit_hit = (MAX_HOLD != 0) && (hold_q >= HOLD_MAX);

    if (MODE == 0) begin
      // Walk downward so the nearest requester after the owner is the final
      // assignment; i = N_MASTERS lands on the owner itself, so it ranks last.
      for (int i = N_MASTERS; i >= 1; i--) begin
        c    = (int'(owner_q) + i) % N_MASTERS;
        cidx = MW'(c);
        if (hbusreq[cidx]) pick = cidx;
      end
    end else begin
      for (int i = N_MASTERS - 1; i >= 0; i--) begin
        if (hbusreq[MW'(i)]) pick = MW'(i);
      end
    end

    if (ap) begin
      if (hbusreq[owner_q] && !limit_hit) next_owner = owner_q;
      else                                next_owner = pick;
      clear_hold = (next_owner != owner_q) || limit_hit;
    end

    next_grant[next_owner] = 1'b1;

    if (clear_hold)                                 next_hold = '0;
    else if (htrans == NONSEQ && hold_q < HOLD_MAX) next_hold = hold_q + HW'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_q   <= DEF_IDX;
      hgrant    <= DEF_GRANT;
      hold_q    <= '0;
      hmaster   <= DEF_IDX;
      hmastlock <= 1'b0;
    end else if (hready) begin
      owner_q   <= next_owner;
      hgrant    <= next_grant;
      hold_q    <= next_hold;
      hmaster   <= owner_q;
      hmastlock <= hlock[owner_q];
    end
  end

endmodule

// File: tb/tb_ahb_arbiter_rr.sv
// Bench for ahb_arbiter_rr: directed scenario tasks plus random traffic checked
// against a rule-level model for four parameterisations.
module tb_ahb_arbiter_rr;

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;

  localparam int CFG_N   [4] = '{3, 3, 3, 5};
  localparam int CFG_MODE[4] = '{0, 1, 0, 0};
  localparam int CFG_MAXH[4] = '{4, 4, 4, 0};
  localparam int CFG_DEF [4] = '{0, 0, 2, 4};

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [2:0] hbusreq = '0, hlock = '0;
  logic [4:0] req5 = '0, lock5 = '0;
  logic [1:0] htrans = IDLE;
  logic       hready = 1'b1;

  logic [2:0] g_rr, g_fp, g_def;
  logic [4:0] g_w;
  logic [1:0] m_rr, m_fp, m_def;
  logic [2:0] m_w;
  logic       l_rr, l_fp, l_def, l_w;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ahb_arbiter_rr #(.N_MASTERS(3), .MODE(0), .MAX_HOLD(4), .DEFAULT_MASTER(0)) u_rr (
    .clk(clk), .resetn(resetn), .hbusreq(hbusreq), .hlock(hlock), .htrans(htrans),
    .hready(hready), .hgrant(g_rr), .hmaster(m_rr), .hmastlock(l_rr));
  ahb_arbiter_rr #(.N_MASTERS(3), .MODE(1), .MAX_HOLD(4), .DEFAULT_MASTER(0)) u_fp (
    .clk(clk), .resetn(resetn), .hbusreq(hbusreq), .hlock(hlock), .htrans(htrans),
    .hready(hready), .hgrant(g_fp), .hmaster(m_fp), .hmastlock(l_fp));
  ahb_arbiter_rr #(.N_MASTERS(3), .MODE(0), .MAX_HOLD(4), .DEFAULT_MASTER(2)) u_def (
    .clk(clk), .resetn(resetn), .hbusreq(hbusreq), .hlock(hlock), .htrans(htrans),
    .hready(hready), .hgrant(g_def), .hmaster(m_def), .hmastlock(l_def));
  ahb_arbiter_rr #(.N_MASTERS(5), .MODE(0), .MAX_HOLD(0), .DEFAULT_MASTER(4)) u_wide (
    .clk(clk), .resetn(resetn), .hbusreq(req5), .hlock(lock5), .htrans(htrans),
    .hready(hready), .hgrant(g_w), .hmaster(m_w), .hmastlock(l_w));

  logic [15:0] dut_g[4];
  logic [3:0]  dut_m[4];
  logic        dut_l[4];
  assign dut_g[0] = {13'b0, g_rr};
  assign dut_g[1] = {13'b0, g_fp};
  assign dut_g[2] = {13'b0, g_def};
  assign dut_g[3] = {11'b0, g_w};
  assign dut_m[0] = {2'b0, m_rr};
  assign dut_m[1] = {2'b0, m_fp};
  assign dut_m[2] = {2'b0, m_def};
  assign dut_m[3] = {1'b0, m_w};
  assign dut_l[0] = l_rr;
  assign dut_l[1] = l_fp;
  assign dut_l[2] = l_def;
  assign dut_l[3] = l_w;

  // Reference model: owner index, NONSEQ count and the lagging address-phase view.
  int m_owner[4], m_hold[4], m_hmaster[4];
  bit m_lock[4];

  task automatic model_step(input int k, input logic [15:0] req, input logic [15:0] lck,
                            input logic [1:0] tr, input logic rdy);
    int  own, nxt, n;
    bit  ap, lim, found;
    if (!rdy) return;
    n   = CFG_N[k];
    own = m_owner[k];
    nxt = own;
    lim = 1'b0;
    ap  = (tr == IDLE || tr == NONSEQ) && !(lck[own] && req[own]);
    if (ap) begin
      lim = (CFG_MAXH[k] != 0) && (m_hold[k] >= CFG_MAXH[k]);
      if (!(req[own] && !lim)) begin
        found = 1'b0;
        if (CFG_MODE[k] == 0) begin
          for (int i = 1; i <= n; i++)
            if (!found && req[(own + i) % n]) begin nxt = (own + i) % n; found = 1'b1; end
        end else begin
          for (int i = 0; i < n; i++)
            if (!found && req[i]) begin nxt = i; found = 1'b1; end
        end
        if (!found) nxt = CFG_DEF[k];
      end
    end
    m_hmaster[k] = own;
    m_lock[k]    = lck[own];
    if (nxt != own || (ap && lim)) m_hold[k] = 0;
    else if (tr == NONSEQ && m_hold[k] < CFG_MAXH[k]) m_hold[k] = m_hold[k] + 1;
    m_owner[k] = nxt;
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < 4; k++) begin
        m_owner[k] = CFG_DEF[k]; m_hold[k] = 0; m_hmaster[k] = CFG_DEF[k]; m_lock[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) model_step(k, {13'b0, hbusreq}, {13'b0, hlock}, htrans, hready);
      model_step(3, {11'b0, req5}, {11'b0, lock5}, htrans, hready);
    end
  end

  // Drive one cycle of stimulus from a falling edge and return on the next one.
  task automatic cyc(input logic [1:0] tr, input logic rdy, input logic [2:0] req,
                     input logic [2:0] lck);
    htrans = tr; hready = rdy; hbusreq = req; hlock = lck;
    @(negedge clk);
  endtask

  task automatic do_reset();
    hbusreq = '0; hlock = '0; req5 = '0; lock5 = '0; htrans = IDLE; hready = 1'b1;
    #2 resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    cyc(IDLE, 1'b1, 3'b010, 3'b000);
    checks++;
    if (g_rr !== 3'b010) begin errors++; $display("FAIL pre_reset_grant got=%b exp=010", g_rr); end
    htrans = NONSEQ;
    @(posedge clk);
    #2 hbusreq = '0; htrans = IDLE; resetn = 1'b0;
    #1;
    checks++;
    if (g_rr !== 3'b001 || m_rr !== 2'd0 || l_rr !== 1'b0) begin
      errors++; $display("FAIL reset_rr got g=%b m=%0d l=%b exp g=001 m=0 l=0", g_rr, m_rr, l_rr);
    end
    checks++;
    if (g_def !== 3'b100 || m_def !== 2'd2) begin
      errors++; $display("FAIL reset_def got g=%b m=%0d exp g=100 m=2", g_def, m_def);
    end
    checks++;
    if (g_w !== 5'b10000 || m_w !== 3'd4 || l_w !== 1'b0) begin
      errors++; $display("FAIL reset_wide got g=%b m=%0d l=%b exp g=10000 m=4 l=0", g_w, m_w, l_w);
    end
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(IDLE, 1'b1, 3'b000, 3'b000);
      checks++;
      if (g_rr !== 3'b001 || m_rr !== 2'd0 || l_rr !== 1'b0 || g_def !== 3'b100) begin
        errors++;
        $display("FAIL idle_hold cyc=%0d got rr g=%b m=%0d l=%b def g=%b exp 001/0/0 100",
                 i, g_rr, m_rr, l_rr, g_def);
      end
    end
  endtask

  task automatic test_round_robin();
    int o, nx;
    do_reset();
    o = 0;
    for (int r = 0; r < 3; r++) begin
      nx = (o + 1) % 3;
      for (int i = 0; i < 4; i++) begin
        cyc(NONSEQ, 1'b1, 3'b111, 3'b000);
        checks++;
        if (g_rr !== 3'(1 << o)) begin
          errors++; $display("FAIL rr_keep owner=%0d beat=%0d got=%b", o, i, g_rr);
        end
        if (i == 0) begin
          checks++;
          if (m_rr !== 2'(o)) begin
            errors++; $display("FAIL rr_hmaster got=%0d exp=%0d", m_rr, o);
          end
        end
      end
      cyc(IDLE, 1'b1, 3'b111, 3'b000);
      checks++;
      if (g_rr !== 3'(1 << nx)) begin
        errors++; $display("FAIL rr_rotate from=%0d got=%b exp=%b", o, g_rr, 3'(1 << nx));
      end
      o = nx;
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    cyc(IDLE, 1'b1, 3'b100, 3'b000);
    checks++;
    if (g_fp !== 3'b100) begin errors++; $display("FAIL fp_take2 got=%b exp=100", g_fp); end
    for (int i = 0; i < 4; i++) begin
      cyc(NONSEQ, 1'b1, 3'b110, 3'b000);
      checks++;
      if (g_fp !== 3'b100) begin errors++; $display("FAIL fp_hold2 beat=%0d got=%b exp=100", i, g_fp); end
    end
    cyc(NONSEQ, 1'b1, 3'b110, 3'b000);
    checks++;
    if (g_fp !== 3'b010) begin errors++; $display("FAIL fp_to1 got=%b exp=010", g_fp); end
    for (int i = 0; i < 4; i++) cyc(NONSEQ, 1'b1, 3'b111, 3'b000);
    checks++;
    if (g_fp !== 3'b010) begin errors++; $display("FAIL fp_hold1 got=%b exp=010", g_fp); end
    for (int i = 0; i < 16; i++) begin
      cyc(NONSEQ, 1'b1, 3'b111, 3'b000);
      checks++;
      if (g_fp !== 3'b001) begin errors++; $display("FAIL fp_master0 cyc=%0d got=%b exp=001", i, g_fp); end
    end
  endtask

  task automatic test_burst();
    logic [1:0] tr[6]  = '{NONSEQ, SEQ, SEQ, SEQ, SEQ, SEQ};
    logic       rdy[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(tr[i], rdy[i], (i == 0) ? 3'b001 : 3'b011, 3'b000);
      checks++;
      if (g_rr !== 3'b001 || m_rr !== 2'd0) begin
        errors++; $display("FAIL burst_hold beat=%0d got g=%b m=%0d exp g=001 m=0", i, g_rr, m_rr);
      end
    end
    cyc(IDLE, 1'b1, 3'b010, 3'b000);
    checks++;
    if (g_rr !== 3'b010 || m_rr !== 2'd0) begin
      errors++; $display("FAIL burst_switch got g=%b m=%0d exp g=010 m=0", g_rr, m_rr);
    end
    cyc(NONSEQ, 1'b1, 3'b010, 3'b000);
    checks++;
    if (m_rr !== 2'd1) begin errors++; $display("FAIL burst_hmaster got=%0d exp=1", m_rr); end
  endtask

  task automatic test_lock();
    do_reset();
    cyc(IDLE, 1'b1, 3'b010, 3'b000);
    for (int i = 0; i < 10; i++) begin
      cyc((i == 3 || i == 7) ? IDLE : NONSEQ, 1'b1, 3'b110, 3'b010);
      checks++;
      if (g_rr !== 3'b010 || l_rr !== 1'b1) begin
        errors++; $display("FAIL lock_hold cyc=%0d got g=%b l=%b exp g=010 l=1", i, g_rr, l_rr);
      end
    end
    cyc(NONSEQ, 1'b1, 3'b110, 3'b000);
    checks++;
    if (g_rr !== 3'b100 || l_rr !== 1'b0) begin
      errors++; $display("FAIL lock_release got g=%b l=%b exp g=100 l=0", g_rr, l_rr);
    end
  endtask

  task automatic test_default();
    do_reset();
    cyc(IDLE, 1'b1, 3'b001, 3'b000);
    checks++;
    if (g_def !== 3'b001) begin errors++; $display("FAIL def_take0 got=%b exp=001", g_def); end
    cyc(IDLE, 1'b0, 3'b000, 3'b000);
    checks++;
    if (g_def !== 3'b001) begin errors++; $display("FAIL def_freeze got=%b exp=001", g_def); end
    cyc(IDLE, 1'b1, 3'b000, 3'b000);
    checks++;
    if (g_def !== 3'b100 || m_def !== 2'd0) begin
      errors++; $display("FAIL def_grant got g=%b m=%0d exp g=100 m=0", g_def, m_def);
    end
    cyc(IDLE, 1'b1, 3'b000, 3'b000);
    checks++;
    if (m_def !== 2'd2) begin errors++; $display("FAIL def_hmaster got=%0d exp=2", m_def); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 800; n++) begin
      req5  = 5'($urandom_range(0, 31));
      lock5 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'b0;
      cyc(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
          ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b0);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (dut_g[k] !== (16'd1 << m_owner[k]) || dut_m[k] !== 4'(m_hmaster[k]) ||
            dut_l[k] !== m_lock[k]) begin
          errors++;
          $display("FAIL rand inst=%0d cyc=%0d got g=%b m=%0d l=%b exp owner=%0d m=%0d l=%b",
                   k, n, dut_g[k], dut_m[k], dut_l[k], m_owner[k], m_hmaster[k], m_lock[k]);
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    resetn = 1'b1;
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_burst();
    test_lock();
    test_default();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
